// File: rtl/matrix_pkg.sv
// rtl/matrix_pkg.sv - shared constants, state enum and index helpers for the matrix stages
package matrix_pkg;

  localparam int N          = 3;
  localparam int DW_DEFAULT = 8;

  // Determinant width: sum of three x*(p*q - r*s) terms needs 3*DW+1 bits.
  function automatic int det_width(input int dw);
    return 3 * dw + 1;
  endfunction

  typedef enum logic [2:0] {
    LOAD  = 3'd0,
    CALC0 = 3'd1,
    CALC1 = 3'd2,
    CALC2 = 3'd3,
    HOLD  = 3'd4
  } mat_state_t;

  function automatic int idx(input int r, input int c);
    return r * N + c;
  endfunction

endpackage

// File: rtl/det_term.sv
// rtl/det_term.sv - combinational cofactor term x*(p*q - r*s) at full signed width
module det_term #(
  parameter int DW = 8
) (
  input  logic [DW-1:0]   x,
  input  logic [DW-1:0]   p,
  input  logic [DW-1:0]   q,
  input  logic [DW-1:0]   r,
  input  logic [DW-1:0]   s,
  output logic [3*DW:0]   term
);

  logic signed [2*DW-1:0] pe, qe, re, se;
  logic signed [2*DW-1:0] pq, rs;
  logic signed [2*DW:0]   diff;
  logic signed [3*DW:0]   xe, de;

  // Operands are sign-extended to the product width so the truncated product is exact.
  assign pe = {{DW{p[DW-1]}}, p};
  assign qe = {{DW{q[DW-1]}}, q};
  assign re = {{DW{r[DW-1]}}, r};
  assign se = {{DW{s[DW-1]}}, s};
  assign pq = pe * qe;
  assign rs = re * se;

  assign diff = {pq[2*DW-1], pq} - {rs[2*DW-1], rs};

  assign xe   = {{(2*DW+1){x[DW-1]}}, x};
  assign de   = {{DW{diff[2*DW]}}, diff};
  assign term = xe * de;

endmodule

// File: rtl/matrix_det_loader.sv
// rtl/matrix_det_loader.sv - serial 3x3 matrix loader with sequential determinant for the inverse stage
module matrix_det_loader
  import matrix_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DW-1:0]          in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [9*DW-1:0]        out_matrix,
  output logic [3*DW:0]          out_det,
  output logic                   out_singular
);

  localparam int DET_W = det_width(DW);

  mat_state_t state, state_next;

  logic [DW-1:0]          slot [9];
  logic [3:0]             counter;
  logic signed [DET_W-1:0] acc, acc_next;
  logic [DET_W-1:0]       term;
  logic [DW-1:0]          op_x, op_p, op_q, op_r, op_s;
  logic                   accept;

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= LOAD;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      LOAD:    if (accept && counter == 4'd8) state_next = CALC0;
      CALC0:   state_next = CALC1;
      CALC1:   state_next = CALC2;
      CALC2:   state_next = HOLD;
      HOLD:    if (out_valid && out_ready) state_next = LOAD;
      default: state_next = LOAD;
    endcase
  end

  always_comb begin
    in_ready  = (state == LOAD);
    out_valid = (state == HOLD);
  end

  // One shared term unit; the CALC state selects which cofactor expansion it evaluates.
  always_comb begin
    op_x = slot[idx(0, 0)];
    op_p = slot[idx(1, 1)];
    op_q = slot[idx(2, 2)];
    op_r = slot[idx(1, 2)];
    op_s = slot[idx(2, 1)];
    case (state)
      CALC1: begin
        op_x = slot[idx(0, 1)];
        op_p = slot[idx(1, 0)];
        op_q = slot[idx(2, 2)];
        op_r = slot[idx(1, 2)];
        op_s = slot[idx(2, 0)];
      end
      CALC2: begin
        op_x = slot[idx(0, 2)];
        op_p = slot[idx(1, 0)];
        op_q = slot[idx(2, 1)];
        op_r = slot[idx(1, 1)];
        op_s = slot[idx(2, 0)];
      end
      default: ;
    endcase
  end

  det_term #(.DW(DW)) u_det_term (
    .x    (op_x),
    .p    (op_p),
    .q    (op_q),
    .r    (op_r),
    .s    (op_s),
    .term (term)
  );

  assign acc_next = (state == CALC1) ? acc - $signed(term) : acc + $signed(term);

  always_ff @(posedge clk) begin
    if (rst) begin
      counter      <= '0;
      acc          <= '0;
      out_det      <= '0;
      out_singular <= 1'b0;
      for (int k = 0; k < 9; k++) slot[k] <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (accept) begin
            slot[counter] <= in_data;
            if (counter == 4'd8) begin
              counter <= '0;
              acc     <= '0;
            end else begin
              counter <= counter + 4'd1;
            end
          end
        end
        CALC0, CALC1: acc <= acc_next;
        CALC2: begin
          acc          <= acc_next;
          out_det      <= acc_next;
          out_singular <= (acc_next == '0);
        end
        default: ;
      endcase
    end
  end

  for (genvar k = 0; k < 9; k++) begin : g_out
    assign out_matrix[k*DW +: DW] = slot[k];
  end

endmodule

// File: tb/tb_matrix_det_loader.sv
// tb/tb_matrix_det_loader.sv - directed self-checking bench for matrix_det_loader
module tb_matrix_det_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [71:0] out_matrix;
  logic [24:0] out_det;
  logic        out_singular;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  matrix_det_loader dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_matrix   (out_matrix),
    .out_det      (out_det),
    .out_singular (out_singular)
  );

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [71:0] mk(input int a0, input int a1, input int a2,
                                     input int a3, input int a4, input int a5,
                                     input int a6, input int a7, input int a8);
    return {8'(a8), 8'(a7), 8'(a6), 8'(a5), 8'(a4), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
  endfunction

  task automatic check_idle(input string tag);
    check({tag, " in_ready"},  72'(in_ready), 72'd1);
    check({tag, " out_valid"}, 72'(out_valid), 72'd0);
  endtask

  // Ends at the negedge of the cycle right after the last element's accepting edge.
  task automatic load(input logic [71:0] m, input int gap);
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = m[k*8 +: 8];
      if (k < 8) begin
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          in_valid = 1'b0;
          in_data  = 8'hee;
        end
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run(input string tag, input logic [71:0] m, input int gap,
                     input logic [24:0] det, input logic sing, input bit hold_test);
    int lat;
    out_ready = !hold_test;
    load(m, gap);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"},  72'(lat), 72'd4);
    check({tag, " matrix"},   out_matrix, m);
    check({tag, " det"},      72'(out_det), 72'(det));
    check({tag, " singular"}, 72'(out_singular), 72'(sing));
    check({tag, " in_ready_hold"}, 72'(in_ready), 72'd0);
    if (hold_test) begin
      for (int c = 0; c < 10; c++) begin
        in_valid = 1'b1;
        in_data  = 8'(c + 40);
        @(negedge clk);
        check({tag, " bp out_valid"}, 72'(out_valid), 72'd1);
        check({tag, " bp in_ready"},   72'(in_ready), 72'd0);
        check({tag, " bp matrix"},     out_matrix, m);
        check({tag, " bp det"},        72'(out_det), 72'(det));
        check({tag, " bp singular"},   72'(out_singular), 72'(sing));
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    @(negedge clk);
    check_idle({tag, " after_accept"});
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_idle("reset");
    check("reset matrix",   out_matrix, 72'd0);
    check("reset det",      72'(out_det), 72'd0);
    check("reset singular", 72'(out_singular), 72'd0);
    rst = 1'b0;

    run("identity", mk(1, 0, 0, 0, 1, 0, 0, 0, 1), 0, 25'd1, 1'b0, 1'b0);
    run("gaps",     mk(1, 2, 3, 0, 1, 4, 5, 6, 0), 2, 25'd1, 1'b0, 1'b0);
    run("singular", mk(1, 2, 3, 2, 4, 6, 7, 8, 9), 0, 25'd0, 1'b1, 1'b1);
    run("neg_ext",  mk(-128, 0, 0, 0, -128, 0, 0, 0, -128), 0, 25'(-2097152), 1'b0, 1'b0);
    run("pos_ext",  mk(127, 0, 0, 0, 127, 0, 0, 0, 127), 1, 25'd2048383, 1'b0, 1'b0);

    // Abort after five elements; the reset cycle also presents an element that must be dropped.
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'(k + 9);
    end
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'd77;
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    check_idle("abort");
    check("abort matrix", out_matrix, 72'd0);
    check("abort det",    72'(out_det), 72'd0);
    run("after_abort", mk(2, 0, 0, 0, 3, 0, 0, 0, 4), 0, 25'd24, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
